tdc_event_buffer: RTL and testbench
===================================

# tdc_event_buffer

Measurement-assembly stage directly downstream of the TDC core. Captures the start fine bin, stop fine bin and coarse count for each start/stop hit pair and computes the signed interval with the Nutt formula. Each result is tagged with a sequence number and queued in a small synchronous FIFO, read out through a valid/ready handshake. Result: the host/readout side sees one self-contained word per measurement, with drop detection.

## Interface
Parameters:
- FINE_W, 5: fine-bin width (thermometer encoder output, 32 bins).
- COARSE_W, 4: coarse counter width.
- TAG_W, 4: sequence tag width.
- DEPTH, 8: FIFO depth in words; power of two, at least 2.

Ports:
- clk  in  1  system clock; only clock.
- reset  in  1  synchronous, active-high; clears all state.
- bin_start  in  FINE_W  start fine bin; sampled when start_valid=1.
- start_valid  in  1  one-cycle pulse, start bin valid this cycle.
- bin_stop  in  FINE_W  stop fine bin; sampled when stop_valid=1.
- coarse  in  COARSE_W  coarse count; sampled with bin_stop.
- stop_valid  in  1  one-cycle pulse, stop bin and coarse valid this cycle.
- out_data  out  TAG_W+COARSE_W+FINE_W+1  {tag, interval}; interval is signed, COARSE_W+FINE_W+1 = 10 bits.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head word.
- fifo_level  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- protocol_err  out  1  sticky: orphan stop or repeated start.

## Operation
- FSM states:
  - IDLE: start_valid captures bin_start and moves to ARMED; stop_valid alone is ignored and sets protocol_err.
  - ARMED: stop_valid captures bin_stop and coarse and moves to CALC; start_valid alone recaptures bin_start, stays in ARMED and sets protocol_err.
  - CALC: computes interval = coarse*2^FINE_W + bin_start − bin_stop, sign-extended to 10 bits. Valid range is −31 to +511; there is no saturation. The result is registered, then the state moves to PUSH.
  - PUSH: writes {tag, interval} to the FIFO if there is space, increments tag (mod 2^TAG_W) and returns to IDLE.
- Simultaneous start_valid and stop_valid:
  - In IDLE, the start is taken and the stop is discarded; protocol_err is not set.
  - In ARMED, the stop wins and the start is dropped; protocol_err is set.
- Hits arriving in CALC or PUSH are dropped and set protocol_err.
- Full FIFO in PUSH with no pop that cycle: the word is dropped, overflow is set, and tag still increments so the consumer sees the gap. If a pop occurs in the same cycle, the push is accepted.
- Pop happens when out_valid && out_ready. out_data holds stable while out_valid=1 and out_ready=0.
- The FIFO is first-word-fall-through: out_data presents the head whenever out_valid=1.

## Timing
- Reset values:
  - FSM: IDLE.
  - out_valid: 0.
  - out_data: 0.
  - fifo_level: 0.
  - overflow: 0.
  - protocol_err: 0.
  - tag: 0.
  - FIFO pointers: 0.
- Reset mid-measurement discards the captured bins and all FIFO contents.
- Latency: stop_valid at cycle N means CALC at N+1 and PUSH at N+2. Into an empty FIFO, out_valid rises at N+3.
- Throughput: at most one measurement per 4 cycles (start, stop, CALC, PUSH). Back-to-back pairs are allowed once the FSM is back in IDLE.
- fifo_level updates the cycle after a push or pop. Simultaneous push and pop leaves it unchanged.
- overflow and protocol_err are asserted the cycle after the causing event and hold until reset.

## Structure
- Package tdc_pkg holds:
  - constants FINE_BINS=32, FINE_W, COARSE_W, TAG_W;
  - the interval width function;
  - the FSM state enum (IDLE, ARMED, CALC, PUSH);
  - the packed result type {tag, interval}.
- Sub-module tdc_sync_fifo: generic DEPTH×WIDTH synchronous FWFT FIFO with push, pop, full, empty and level. It is reusable for the stop path later.
- Top file: FSM, capture registers, arithmetic, tag counter, sticky flags.

## Test plan
- Reset, then start bin 10, 3 cycles later stop bin 3 with coarse 5, out_ready=1 → out_valid at stop+3; out_data = {tag 0, interval 167}; fifo_level returns to 0.
- Start bin 0, stop bin 31, coarse 0 → interval −31 (10'h3E1). Start bin 31, stop bin 0, coarse 15 → interval 511.
- Hold out_ready=0 and run 10 valid pairs → fifo_level=8, overflow=1, stored tags 0–7. Then release out_ready and run one more pair → its word carries tag 10.
- Stop pulse in IDLE → no FIFO write, protocol_err=1. Two starts (bins 4, then 9) followed by stop bin 2 with coarse 1 → interval 39.
- Same-cycle start+stop in IDLE, then stop bin 1 with coarse 2 → one word with interval 64+start−1; protocol_err stays 0.
- Assert reset while in ARMED with 3 words queued → next cycle out_valid=0, fifo_level=0, tag restarts at 0, both flags cleared.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared constants, types and helpers for the TDC measurement-assembly stage.
// The result word is {sequence tag, signed Nutt interval}.
package tdc_pkg;

   localparam int FINE_BINS = 32;
   localparam int FINE_W    = 5;
   localparam int COARSE_W  = 4;
   localparam int TAG_W     = 4;

   // One extra bit so that a stop bin later than the start bin goes negative
   function automatic int intervalWidth(input int fineW, input int coarseW);
      return coarseW + fineW + 1;
   endfunction

   localparam int IV_W = intervalWidth(FINE_W, COARSE_W);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CALC,
      PUSH
   } state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IV_W-1:0]  interval;
   } result_t;

endpackage

// File: rtl/tdc_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy output.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module tdc_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 14,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] popData_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);

   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic             doPush;
   logic             doPop;

   assign level_o   = wrPtr_q - rdPtr_q;
   assign full_o    = (level_o == FULL_LEVEL);
   assign empty_o   = (level_o == '0);
   assign doPop     = pop_i && !empty_o;
   assign doPush    = push_i && (!full_o || doPop);
   assign popData_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage needs no reset: the pointers alone decide what is visible
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
   end

endmodule

// File: rtl/tdc_event_buffer.sv
// Pairs start/stop hits, forms the signed Nutt interval, tags it and queues it for readout.
// Sticky flags report dropped results and out-of-order hits.
module tdc_event_buffer #(
   parameter int FINE_W   = tdc_pkg::FINE_W,
   parameter int COARSE_W = tdc_pkg::COARSE_W,
   parameter int TAG_W    = tdc_pkg::TAG_W,
   parameter int DEPTH    = 8,
   localparam int IV_W    = tdc_pkg::intervalWidth(FINE_W, COARSE_W)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [FINE_W-1:0]       bin_start,
   input  logic                    start_valid,
   input  logic [FINE_W-1:0]       bin_stop,
   input  logic [COARSE_W-1:0]     coarse,
   input  logic                    stop_valid,
   output logic [TAG_W+IV_W-1:0]   out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    overflow,
   output logic                    protocol_err
);

   import tdc_pkg::*;

   state_t              state_q, state_d;
   logic [FINE_W-1:0]   startBin_q, startBin_d;
   logic [FINE_W-1:0]   stopBin_q, stopBin_d;
   logic [COARSE_W-1:0] coarse_q, coarse_d;
   logic [IV_W-1:0]     interval_q, interval_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic                overflow_q, overflow_d;
   logic                protoErr_q, protoErr_d;
   logic                fifoFull;
   logic                fifoEmpty;
   logic                fifoPop;
   logic                fifoPush;

   assign fifoPop      = out_valid && out_ready;
   assign fifoPush     = (state_q == PUSH);
   assign out_valid    = !fifoEmpty;
   assign overflow     = overflow_q;
   assign protocol_err = protoErr_q;

   // coarse*2^FINE_W + start is just the concatenation {coarse, start}
   always_comb begin
      state_d    = state_q;
      startBin_d = startBin_q;
      stopBin_d  = stopBin_q;
      coarse_d   = coarse_q;
      interval_d = interval_q;
      tag_d      = tag_q;
      overflow_d = overflow_q;
      protoErr_d = protoErr_q;
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               startBin_d = bin_start;
               state_d    = ARMED;
            end else if (stop_valid) begin
               protoErr_d = 1'b1;
            end
         end
         ARMED: begin
            if (stop_valid) begin
               stopBin_d = bin_stop;
               coarse_d  = coarse;
               state_d   = CALC;
               if (start_valid) protoErr_d = 1'b1;
            end else if (start_valid) begin
               startBin_d = bin_start;
               protoErr_d = 1'b1;
            end
         end
         CALC: begin
            interval_d = {1'b0, coarse_q, startBin_q} - {{(COARSE_W + 1){1'b0}}, stopBin_q};
            state_d    = PUSH;
            if (start_valid || stop_valid) protoErr_d = 1'b1;
         end
         PUSH: begin
            tag_d   = tag_q + 1'b1;
            state_d = IDLE;
            if (fifoFull && !fifoPop) overflow_d = 1'b1;
            if (start_valid || stop_valid) protoErr_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         startBin_q <= '0;
         stopBin_q  <= '0;
         coarse_q   <= '0;
         interval_q <= '0;
         tag_q      <= '0;
         overflow_q <= 1'b0;
         protoErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         startBin_q <= startBin_d;
         stopBin_q  <= stopBin_d;
         coarse_q   <= coarse_d;
         interval_q <= interval_d;
         tag_q      <= tag_d;
         overflow_q <= overflow_d;
         protoErr_q <= protoErr_d;
      end
   end

   tdc_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (TAG_W + IV_W)
   ) uFifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (fifoPush),
      .pushData_i ({tag_q, interval_q}),
      .pop_i      (fifoPop),
      .popData_o  (out_data),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .level_o    (fifo_level)
   );

endmodule

// File: tb/tb_tdc_event_buffer.sv
// Self-checking bench for tdc_event_buffer: directed scenarios plus random hits and back-pressure,
// compared every cycle against a transaction-level model (pairing rules, result queue, tag counter).
module tb_tdc_event_buffer;

   import tdc_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  bin_start;
   logic        start_valid;
   logic [4:0]  bin_stop;
   logic [3:0]  coarse;
   logic        stop_valid;
   logic [13:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  fifo_level;
   logic        overflow;
   logic        protocol_err;

   int errors = 0;
   int checks = 0;

   // Reference model state
   result_t mQueue[$];
   int      mTag;
   bit      mArmed;
   int      mBusy;
   int      mStart;
   int      mStop;
   int      mCoarse;
   bit      mOvf;
   bit      mErr;

   always #5 clk = ~clk;

   tdc_event_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .bin_start    (bin_start),
      .start_valid  (start_valid),
      .bin_stop     (bin_stop),
      .coarse       (coarse),
      .stop_valid   (stop_valid),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .protocol_err (protocol_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelClear();
      mQueue.delete();
      mTag   = 0;
      mArmed = 0;
      mBusy  = 0;
      mOvf   = 0;
      mErr   = 0;
   endtask

   // One clock of the measurement rules: a pair occupies one compute cycle and one store cycle after its stop
   task automatic modelStep(input bit st, input int bs, input bit sp, input int bp, input int co);
      bit      pop;
      bit      wasFull;
      result_t r;
      pop     = (mQueue.size() > 0) && out_ready;
      wasFull = (mQueue.size() == DEPTH);
      if (pop) void'(mQueue.pop_front());
      if (mBusy == 2) begin
         if (st || sp) mErr = 1;
         mBusy = 1;
      end else if (mBusy == 1) begin
         if (st || sp) mErr = 1;
         if (!wasFull || pop) begin
            r.tag      = 4'(mTag);
            r.interval = 10'(mCoarse * FINE_BINS + mStart - mStop);
            mQueue.push_back(r);
         end else begin
            mOvf = 1;
         end
         mTag  = (mTag + 1) % 16;
         mBusy = 0;
      end else if (!mArmed) begin
         if (st) begin
            mStart = bs;
            mArmed = 1;
         end else if (sp) begin
            mErr = 1;
         end
      end else begin
         if (sp) begin
            mStop   = bp;
            mCoarse = co;
            mArmed  = 0;
            mBusy   = 2;
            if (st) mErr = 1;
         end else if (st) begin
            mStart = bs;
            mErr   = 1;
         end
      end
   endtask

   // Called at a falling edge: drive this cycle's hits, check outputs, advance the model and the clock
   task automatic applyStimulus(input bit st, input int bs, input bit sp, input int bp, input int co);
      start_valid = st;
      bin_start   = 5'(bs);
      stop_valid  = sp;
      bin_stop    = 5'(bp);
      coarse      = 4'(co);
      checkOutput("outValid", 32'(out_valid), 32'(mQueue.size() > 0));
      checkOutput("fifoLevel", 32'(fifo_level), 32'(mQueue.size()));
      if (mQueue.size() > 0) checkOutput("outData", 32'(out_data), 32'(mQueue[0]));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
      checkOutput("protoErr", 32'(protocol_err), 32'(mErr));
      modelStep(st, bs, sp, bp, co);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
   endtask

   task automatic measurePair(input int bs, input int bp, input int co, input int gap);
      applyStimulus(1, bs, 0, 0, 0);
      idleCycles(gap);
      applyStimulus(0, 0, 1, bp, co);
      idleCycles(2);
   endtask

   task automatic doReset();
      reset       = 1'b1;
      start_valid = 1'b0;
      stop_valid  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      modelClear();
      checkOutput("resetData", 32'(out_data), 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      out_ready   = 1'b1;
      bin_start   = '0;
      bin_stop    = '0;
      coarse      = '0;
      start_valid = 1'b0;
      stop_valid  = 1'b0;
      @(negedge clk);
      doReset();

      // Basic measurement and the two range extremes
      measurePair(10, 3, 5, 2);
      checkOutput("firstWord", 32'(out_data), 32'(14'h00A7));
      idleCycles(2);
      measurePair(0, 31, 0, 0);
      checkOutput("minInterval", 32'(out_data), 32'({4'd1, 10'h3E1}));
      idleCycles(1);
      measurePair(31, 0, 15, 1);
      checkOutput("maxInterval", 32'(out_data), 32'({4'd2, 10'h1FF}));
      idleCycles(2);

      // Back-pressure until overflow, then drain while one more pair arrives
      doReset();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) measurePair(i, i + 1, i % 16, 0);
      checkOutput("fullLevel", 32'(fifo_level), 32'd8);
      out_ready = 1'b1;
      measurePair(7, 2, 3, 0);
      idleCycles(12);

      // Protocol violations
      doReset();
      applyStimulus(0, 0, 1, 7, 3);
      idleCycles(1);
      applyStimulus(1, 4, 0, 0, 0);
      applyStimulus(1, 9, 0, 0, 0);
      applyStimulus(0, 0, 1, 2, 1);
      idleCycles(4);

      doReset();
      applyStimulus(1, 6, 1, 20, 7);
      applyStimulus(0, 0, 1, 1, 2);
      idleCycles(4);
      checkOutput("simulNoErr", 32'(protocol_err), 32'd0);

      // Reset while armed with queued words
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) measurePair(5, 5, i + 1, 0);
      applyStimulus(1, 12, 0, 0, 0);
      doReset();
      checkOutput("rstValid", 32'(out_valid), 32'd0);
      checkOutput("rstLevel", 32'(fifo_level), 32'd0);
      out_ready = 1'b1;
      measurePair(3, 3, 1, 0);
      checkOutput("rstTag", 32'(out_data), 32'({4'd0, 10'd32}));
      idleCycles(2);

      // Random hits, back-pressure and occasional resets
      for (int c = 0; c < 3000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0) || (c < 1000 && c % 2 == 0);
         if ($urandom_range(0, 299) == 0) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 31),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 31), $urandom_range(0, 15));
         end
      end
      out_ready = 1'b1;
      idleCycles(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
